// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with hazard bubble insertion and bubble counter
module id_ex_stage_reg #(
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                do_hazard,
    input  logic                do_flush,
    input  logic                id_valid,
    input  logic                id_do_reg_write,
    input  logic                id_do_dm_read,
    input  logic                id_do_dm_write,
    input  logic [1:0]          id_select_write_reg,
    input  logic [4:0]          id_write_reg_addr,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [31:0]         id_imm_extend,
    input  logic [31:0]         id_pc,
    input  logic [31:0]         f_reg_ra_data,
    input  logic [31:0]         f_reg_rb_data,
    input  logic [31:0]         f_reg_rt_data,
    output logic                xREG2_valid,
    output logic                xREG2_do_reg_write,
    output logic                xREG2_do_dm_read,
    output logic                xREG2_do_dm_write,
    output logic [1:0]          xREG2_select_write_reg,
    output logic [4:0]          xREG2_write_reg_addr,
    output logic [ALU_OP_W-1:0] xREG2_alu_op,
    output logic [31:0]         xREG2_imm_extend,
    output logic [31:0]         xREG2_pc,
    output logic [31:0]         xREG2_ra_data,
    output logic [31:0]         xREG2_rb_data,
    output logic [31:0]         xREG2_rt_data,
    output logic                hold_ifid,
    output logic [CNT_W-1:0]    bubble_count
);

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   take_hazard;
    logic   insert_bubble;

    // A flush kills the ID instruction outright, so it overrides any hazard stall.
    assign take_hazard   = do_hazard & ~do_flush;
    assign insert_bubble = do_flush | do_hazard;
    assign hold_ifid     = take_hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A hazard seen while already in BUBBLE just re-enters BUBBLE, so there is no lockup.
    always_comb begin
        state_d = RUN;
        case (state_q)
            RUN:     state_d = take_hazard ? BUBBLE : RUN;
            BUBBLE:  state_d = take_hazard ? BUBBLE : RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count <= '0;
        end else if (take_hazard && !(&bubble_count)) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xREG2_valid            <= 1'b0;
            xREG2_do_reg_write     <= 1'b0;
            xREG2_do_dm_read       <= 1'b0;
            xREG2_do_dm_write      <= 1'b0;
            xREG2_select_write_reg <= 2'b00;
            xREG2_write_reg_addr   <= 5'd0;
            xREG2_alu_op           <= '0;
            xREG2_imm_extend       <= 32'd0;
            xREG2_pc               <= 32'd0;
            xREG2_ra_data          <= 32'd0;
            xREG2_rb_data          <= 32'd0;
            xREG2_rt_data          <= 32'd0;
        end else if (insert_bubble) begin
            // Bubble clears only the control fields; data fields hold their last values.
            xREG2_valid            <= 1'b0;
            xREG2_do_reg_write     <= 1'b0;
            xREG2_do_dm_read       <= 1'b0;
            xREG2_do_dm_write      <= 1'b0;
            xREG2_select_write_reg <= 2'b00;
            xREG2_alu_op           <= '0;
        end else begin
            xREG2_valid            <= id_valid;
            xREG2_do_reg_write     <= id_do_reg_write & id_valid;
            xREG2_do_dm_read       <= id_do_dm_read & id_valid;
            xREG2_do_dm_write      <= id_do_dm_write & id_valid;
            xREG2_select_write_reg <= id_select_write_reg;
            xREG2_write_reg_addr   <= id_write_reg_addr;
            xREG2_alu_op           <= id_alu_op;
            xREG2_imm_extend       <= id_imm_extend;
            xREG2_pc               <= id_pc;
            xREG2_ra_data          <= f_reg_ra_data;
            xREG2_rb_data          <= f_reg_rb_data;
            xREG2_rt_data          <= f_reg_rt_data;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

    localparam int AW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          do_hazard, do_flush, id_valid;
    logic          id_do_reg_write, id_do_dm_read, id_do_dm_write;
    logic [1:0]    id_select_write_reg;
    logic [4:0]    id_write_reg_addr;
    logic [AW-1:0] id_alu_op;
    logic [31:0]   id_imm_extend, id_pc, f_reg_ra_data, f_reg_rb_data, f_reg_rt_data;
    logic          x_valid, x_rw, x_dr, x_dw, hold_ifid;
    logic [1:0]    x_sel;
    logic [4:0]    x_addr;
    logic [AW-1:0] x_alu;
    logic [31:0]   x_imm, x_pc, x_ra, x_rb, x_rt;
    logic [CW-1:0] bubble_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    id_ex_stage_reg #(.ALU_OP_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .do_hazard(do_hazard), .do_flush(do_flush),
        .id_valid(id_valid), .id_do_reg_write(id_do_reg_write),
        .id_do_dm_read(id_do_dm_read), .id_do_dm_write(id_do_dm_write),
        .id_select_write_reg(id_select_write_reg), .id_write_reg_addr(id_write_reg_addr),
        .id_alu_op(id_alu_op), .id_imm_extend(id_imm_extend), .id_pc(id_pc),
        .f_reg_ra_data(f_reg_ra_data), .f_reg_rb_data(f_reg_rb_data),
        .f_reg_rt_data(f_reg_rt_data),
        .xREG2_valid(x_valid), .xREG2_do_reg_write(x_rw), .xREG2_do_dm_read(x_dr),
        .xREG2_do_dm_write(x_dw), .xREG2_select_write_reg(x_sel),
        .xREG2_write_reg_addr(x_addr), .xREG2_alu_op(x_alu), .xREG2_imm_extend(x_imm),
        .xREG2_pc(x_pc), .xREG2_ra_data(x_ra), .xREG2_rb_data(x_rb), .xREG2_rt_data(x_rt),
        .hold_ifid(hold_ifid), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    // Expected EX-stage contents, derived from the stage rules.
    typedef struct {
        logic          valid, rw, dr, dw;
        logic [1:0]    sel;
        logic [4:0]    addr;
        logic [AW-1:0] alu;
        logic [31:0]   imm, pc, ra, rb, rt;
        int            count;
    } ex_t;
    ex_t m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m = '{default: 0};
        end else if (do_flush || do_hazard) begin
            m.valid = 0; m.rw = 0; m.dr = 0; m.dw = 0; m.sel = 0; m.alu = 0;
            if (!do_flush && m.count < 15) m.count = m.count + 1;
        end else begin
            m.valid = id_valid;
            m.rw = id_valid && id_do_reg_write;
            m.dr = id_valid && id_do_dm_read;
            m.dw = id_valid && id_do_dm_write;
            m.sel = id_select_write_reg; m.addr = id_write_reg_addr; m.alu = id_alu_op;
            m.imm = id_imm_extend; m.pc = id_pc;
            m.ra = f_reg_ra_data; m.rb = f_reg_rb_data; m.rt = f_reg_rt_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_valid", 32'(x_valid), 32'(m.valid));
            chk("m_reg_write", 32'(x_rw), 32'(m.rw));
            chk("m_dm_read", 32'(x_dr), 32'(m.dr));
            chk("m_dm_write", 32'(x_dw), 32'(m.dw));
            chk("m_sel", 32'(x_sel), 32'(m.sel));
            chk("m_addr", 32'(x_addr), 32'(m.addr));
            chk("m_alu", 32'(x_alu), 32'(m.alu));
            chk("m_imm", x_imm, m.imm);
            chk("m_pc", x_pc, m.pc);
            chk("m_ra", x_ra, m.ra);
            chk("m_rb", x_rb, m.rb);
            chk("m_rt", x_rt, m.rt);
            chk("m_count", 32'(bubble_count), 32'(m.count));
            chk("m_hold", 32'(hold_ifid), 32'(do_hazard && !do_flush));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic rw, input logic dr, input logic dw,
                             input logic [4:0] addr, input logic [31:0] base);
        id_valid = v; id_do_reg_write = rw; id_do_dm_read = dr; id_do_dm_write = dw;
        id_write_reg_addr = addr; id_select_write_reg = base[1:0]; id_alu_op = base[3:0];
        id_imm_extend = base + 32'h44; id_pc = base + 32'h100;
        f_reg_ra_data = base + 32'h11; f_reg_rb_data = base + 32'h22; f_reg_rt_data = base + 32'h33;
    endtask

    initial begin
        do_hazard = 0; do_flush = 0;
        set_instr(1, 1, 1, 1, 5'd9, 32'hA5A5_0000);
        #3;
        chk("rst_valid", 32'(x_valid), 32'd0);
        chk("rst_ra", x_ra, 32'd0);
        chk("rst_pc", x_pc, 32'd0);
        chk("rst_count", 32'(bubble_count), 32'd0);
        step(); step();
        rst = 0;
        cmp_en = 1;

        // Pass-through
        set_instr(1, 1, 0, 0, 5'd5, 32'h0);
        step();
        chk("pt_valid", 32'(x_valid), 32'd1);
        chk("pt_rw", 32'(x_rw), 32'd1);
        chk("pt_addr", 32'(x_addr), 32'd5);
        chk("pt_ra", x_ra, 32'h11);
        chk("pt_rb", x_rb, 32'h22);
        chk("pt_rt", x_rt, 32'h33);
        chk("pt_imm", x_imm, 32'h44);
        chk("pt_pc", x_pc, 32'h100);

        // Load-use stall for one cycle, then the held instruction goes through
        set_instr(1, 1, 0, 0, 5'd7, 32'h1000);
        do_hazard = 1;
        #1 chk("lu_hold", 32'(hold_ifid), 32'd1);
        step();
        do_hazard = 0;
        chk("lu_valid", 32'(x_valid), 32'd0);
        chk("lu_rw", 32'(x_rw), 32'd0);
        chk("lu_count", 32'(bubble_count), 32'd1);
        chk("lu_ra_kept", x_ra, 32'h11);
        step();
        chk("lu_cap_valid", 32'(x_valid), 32'd1);
        chk("lu_cap_ra", x_ra, 32'h1011);

        // Hazard and flush together
        do_hazard = 1; do_flush = 1;
        #1 chk("hf_hold", 32'(hold_ifid), 32'd0);
        step();
        do_hazard = 0; do_flush = 0;
        chk("hf_valid", 32'(x_valid), 32'd0);
        chk("hf_count", 32'(bubble_count), 32'd1);

        // Saturation: back-to-back hazards, including while already in BUBBLE
        do_hazard = 1;
        for (int i = 0; i < 20; i++) step();
        chk("sat_count", 32'(bubble_count), 32'd15);
        step();
        chk("sat_hold", 32'(bubble_count), 32'd15);
        do_hazard = 0;
        step();
        chk("sat_exit_valid", 32'(x_valid), 32'd1);

        // Invalid instruction: captured, but write enables suppressed
        set_instr(0, 1, 1, 1, 5'd3, 32'h2000);
        step();
        chk("inv_dw", 32'(x_dw), 32'd0);
        chk("inv_valid", 32'(x_valid), 32'd0);
        chk("inv_ra", x_ra, 32'h2011);

        // Directed mix of flush, hazard and normal captures
        for (int i = 0; i < 24; i++) begin
            set_instr(logic'(i % 3 != 0), logic'(i[0]), logic'(i[1]), logic'(i[2]),
                      5'(i), 32'h3000 + 32'(i) * 32'h101);
            do_hazard = (i % 5 == 1) || (i % 7 == 3);
            do_flush  = (i % 6 == 4);
            step();
        end
        do_hazard = 0; do_flush = 0;
        step();

        // Asynchronous reset in the middle of a stall
        set_instr(1, 1, 1, 0, 5'd12, 32'h4000);
        step();
        do_hazard = 1;
        #2 rst = 1;
        #1;
        chk("ar_valid", 32'(x_valid), 32'd0);
        chk("ar_ra", x_ra, 32'd0);
        chk("ar_count", 32'(bubble_count), 32'd0);
        chk("ar_hold", 32'(hold_ifid), 32'd1);
        step();
        rst = 0;
        do_hazard = 0;
        step();
        chk("ar_recover_ra", x_ra, 32'h4011);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
